// File: rtl/move_entry.sv
// move_entry: turns three bouncy push buttons (next / prev / confirm) into a
// cursor over a 3x3 board and single-cycle move / reject strobes for the
// tic-tac-toe engine. Each button is synchronized, debounced, and edge
// detected. The confirm handling is locked out until the button is released.
module move_entry #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned CNT_W           = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_next,
    input  logic       btn_prev,
    input  logic       btn_confirm,
    input  logic       enable,
    input  logic [8:0] occupied,
    output logic       move_valid,
    output logic [3:0] move_pos,
    output logic       reject,
    output logic [3:0] cursor
);

    // Counter value on which a persistent level difference is accepted.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Button lanes: 0 = next, 1 = prev, 2 = confirm.
    localparam int unsigned NB = 3;

    // Cursor step forward, wrapping 8 -> 0; any out-of-range value recovers to 0.
    function automatic logic [3:0] cursor_inc(input logic [3:0] c);
        logic [3:0] r;
        if (c >= 4'd8) begin
            r = 4'd0;
        end else begin
            r = c + 4'd1;
        end
        return r;
    endfunction

    // Cursor step back, wrapping 0 -> 8; any out-of-range value recovers to 8.
    function automatic logic [3:0] cursor_dec(input logic [3:0] c);
        logic [3:0] r;
        if ((c == 4'd0) || (c > 4'd8)) begin
            r = 4'd8;
        end else begin
            r = c - 4'd1;
        end
        return r;
    endfunction

    logic [NB-1:0]    raw_s;
    logic [NB-1:0]    sync1_r;
    logic [NB-1:0]    sync2_r;
    logic [NB-1:0]    stable_r;
    logic [NB-1:0]    stable_next_s;
    logic [CNT_W-1:0] cnt_r      [NB];
    logic [CNT_W-1:0] cnt_next_s [NB];
    logic [NB-1:0]    rise_s;
    logic [NB-1:0]    rise_r;

    logic             lock_r;
    logic             lock_next_s;
    logic             confirm_ev_s;
    logic [3:0]       cursor_r;
    logic [3:0]       cursor_next_s;
    logic             move_valid_r;
    logic             move_valid_next_s;
    logic             reject_r;
    logic             reject_next_s;
    logic [3:0]       move_pos_r;
    logic [3:0]       move_pos_next_s;

    assign raw_s = {btn_confirm, btn_prev, btn_next};

    // Two-flop synchronizers for the asynchronous button inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 3'b000;
            sync2_r <= 3'b000;
        end else begin
            sync1_r <= raw_s;
            sync2_r <= sync1_r;
        end
    end

    // Debounce next-state: accept a new level after DEBOUNCE_CYCLES differing samples.
    always_comb begin
        stable_next_s = stable_r;
        rise_s        = 3'b000;
        for (int b = 0; b < NB; b++) begin
            cnt_next_s[b] = '0;
            if (sync2_r[b] == stable_r[b]) begin
                cnt_next_s[b] = '0;
            end else if (cnt_r[b] == CNT_LAST) begin
                stable_next_s[b] = sync2_r[b];
                cnt_next_s[b]    = '0;
                rise_s[b]        = sync2_r[b];
            end else begin
                cnt_next_s[b] = cnt_r[b] + CNT_W'(1);
            end
        end
    end

    // Debounce state and registered one-cycle rising-edge events.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_r <= 3'b000;
            rise_r   <= 3'b000;
            for (int b = 0; b < NB; b++) begin
                cnt_r[b] <= '0;
            end
        end else begin
            stable_r <= stable_next_s;
            rise_r   <= rise_s;
            for (int b = 0; b < NB; b++) begin
                cnt_r[b] <= cnt_next_s[b];
            end
        end
    end

    assign confirm_ev_s = rise_r[2] & ~lock_r;

    // Move control: confirm wins over cursor motion; next+prev together cancel.
    always_comb begin
        cursor_next_s     = cursor_r;
        move_valid_next_s = 1'b0;
        reject_next_s     = 1'b0;
        move_pos_next_s   = move_pos_r;
        lock_next_s       = lock_r;
        if (confirm_ev_s) begin
            lock_next_s = 1'b1;
            if (enable && !occupied[cursor_r]) begin
                move_valid_next_s = 1'b1;
                move_pos_next_s   = cursor_r;
            end else begin
                reject_next_s = 1'b1;
            end
        end else begin
            case ({rise_r[1], rise_r[0]})
                2'b01:   cursor_next_s = cursor_inc(cursor_r);
                2'b10:   cursor_next_s = cursor_dec(cursor_r);
                default: cursor_next_s = cursor_r;
            endcase
            if (!stable_r[2]) begin
                lock_next_s = 1'b0;
            end else begin
                lock_next_s = lock_r;
            end
        end
    end

    // Registered cursor, strobes, move position and confirm lockout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cursor_r     <= 4'd0;
            move_valid_r <= 1'b0;
            reject_r     <= 1'b0;
            move_pos_r   <= 4'd0;
            lock_r       <= 1'b0;
        end else begin
            cursor_r     <= cursor_next_s;
            move_valid_r <= move_valid_next_s;
            reject_r     <= reject_next_s;
            move_pos_r   <= move_pos_next_s;
            lock_r       <= lock_next_s;
        end
    end

    assign cursor     = cursor_r;
    assign move_valid = move_valid_r;
    assign reject     = reject_r;
    assign move_pos   = move_pos_r;

endmodule

// File: tb/tb_move_entry.sv
// Testbench for move_entry: directed scenarios plus random button activity.
// A reference model derives debounced events from a sliding window of
// synchronized samples and pushes expected strobes into a scoreboard queue;
// a monitor on the falling edge pops and compares whenever a strobe appears.
module tb_move_entry;

    localparam int D = 4;

    logic       clk;
    logic       rst_n;
    logic [2:0] btn;
    logic       enable;
    logic [8:0] occupied;
    logic       move_valid;
    logic [3:0] move_pos;
    logic       reject;
    logic [3:0] cursor;

    move_entry #(.DEBOUNCE_CYCLES(D), .CNT_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_next   (btn[0]),
        .btn_prev   (btn[1]),
        .btn_confirm(btn[2]),
        .enable     (enable),
        .occupied   (occupied),
        .move_valid (move_valid),
        .move_pos   (move_pos),
        .reject     (reject),
        .cursor     (cursor)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        bit is_valid;
        int pos;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    // Reference model state
    bit   m_s1[3];
    bit   m_s2[3];
    bit   m_stab[3];
    bit   m_pev[3];
    bit   m_win0[$];
    bit   m_win1[$];
    bit   m_win2[$];
    bit   m_lock = 1'b0;
    int   m_cur = 0;
    int   m_pos = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Accept a new level when the last D synchronized samples all differ from it.
    function automatic bit window_flip(input bit win[$], input bit stab);
        bit f;
        f = (win.size() == D);
        foreach (win[i]) if (win[i] == stab) f = 1'b0;
        return f;
    endfunction

    // Behavioural reference model, stepped on every clock edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 3; b++) begin
                m_s1[b] = 0; m_s2[b] = 0; m_stab[b] = 0; m_pev[b] = 0;
            end
            m_win0.delete(); m_win1.delete(); m_win2.delete();
            m_lock = 0; m_cur = 0; m_pos = 0;
            q.delete();
        end else begin
            bit flip[3];
            bit nev[3];
            cyc++;
            // Act on events debounced at the previous edge
            if (m_pev[2] && !m_lock) begin
                exp_t e;
                e.cyc = cyc;
                if (enable && !occupied[m_cur]) begin
                    e.is_valid = 1; e.pos = m_cur; m_pos = m_cur;
                end else begin
                    e.is_valid = 0; e.pos = m_pos;
                end
                q.push_back(e);
                m_lock = 1;
            end else begin
                if (m_pev[0] && !m_pev[1]) m_cur = (m_cur + 1) % 9;
                if (m_pev[1] && !m_pev[0]) m_cur = (m_cur + 8) % 9;
                if (!m_stab[2]) m_lock = 0;
            end
            // Debounce on the synchronized samples
            m_win0.push_back(m_s2[0]); if (m_win0.size() > D) void'(m_win0.pop_front());
            m_win1.push_back(m_s2[1]); if (m_win1.size() > D) void'(m_win1.pop_front());
            m_win2.push_back(m_s2[2]); if (m_win2.size() > D) void'(m_win2.pop_front());
            flip[0] = window_flip(m_win0, m_stab[0]);
            flip[1] = window_flip(m_win1, m_stab[1]);
            flip[2] = window_flip(m_win2, m_stab[2]);
            for (int b = 0; b < 3; b++) begin
                nev[b] = flip[b] && !m_stab[b];
                if (flip[b]) m_stab[b] = !m_stab[b];
                m_pev[b] = nev[b];
                m_s2[b]  = m_s1[b];
                m_s1[b]  = btn[b];
            end
        end
    end

    // Monitor: compare outputs against the model on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("reset_outputs", {move_valid, reject, move_pos, cursor}, 0);
        end else begin
            chk("cursor", cursor, m_cur);
            chk("move_pos_hold", move_pos, m_pos);
            if (move_valid && reject) chk("valid_and_reject", 1, 0);
            if (move_valid || reject) begin
                if (q.size() == 0) begin
                    chk("unexpected_strobe", {move_valid, reject}, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("strobe_cycle", cyc, e.cyc);
                    chk("strobe_kind_valid", move_valid, e.is_valid);
                    chk("strobe_kind_reject", reject, !e.is_valid);
                    if (move_valid) chk("strobe_pos", move_pos, e.pos);
                end
            end else if (q.size() != 0 && q[0].cyc <= cyc) begin
                chk("missing_strobe_at", cyc, -1);
                void'(q.pop_front());
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #3;
    endtask

    task automatic press(input int b);
        btn[b] = 1'b1;
        cycles(D + 6);
        btn[b] = 1'b0;
        cycles(D + 6);
    endtask

    initial begin
        rst_n = 1'b0; btn = 3'b000; enable = 1'b1; occupied = 9'h000;
        cycles(3);
        rst_n = 1'b1;
        cycles(2);

        // Nine next presses walk the cursor all the way round to 0
        for (int i = 0; i < 9; i++) press(0);
        chk("wrap_cursor", m_cur, 0);

        // Prev from 0 wraps to 8, then back with next
        press(1);
        press(0);

        // Bouncing confirm, then held: one move at cell 0
        for (int i = 0; i < 10; i++) begin
            btn[2] = ~btn[2];
            cycles(2);
        end
        btn[2] = 1'b1;
        cycles(12);
        btn[2] = 1'b0;
        cycles(D + 6);

        // Cursor to 4: occupied cell rejects, free cell moves
        for (int i = 0; i < 9 && m_cur != 4; i++) press(0);
        occupied = 9'h010;
        press(2);
        occupied = 9'h000;
        press(2);

        // Game not accepting: reject only; long hold gives one strobe
        enable = 1'b0;
        press(2);
        enable = 1'b1;
        btn[2] = 1'b1;
        cycles(50);
        btn[2] = 1'b0;
        cycles(D + 6);

        // All three buttons together at cursor 0
        for (int i = 0; i < 9 && m_cur != 0; i++) press(0);
        btn = 3'b111;
        cycles(D + 6);
        btn = 3'b000;
        cycles(D + 6);
        chk("simul_cursor", m_cur, 0);

        // Reset while the confirm counter sits at 3
        btn[2] = 1'b1;
        cycles(5);
        rst_n = 1'b0;
        btn[2] = 1'b0;
        cycles(3);
        rst_n = 1'b1;
        cycles(D + 8);

        // Random button chatter with varying game state
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < 3; b++)
                if ($urandom_range(0, 5) == 0) btn[b] = ~btn[b];
            if ($urandom_range(0, 99) == 0) enable = ~enable;
            if ($urandom_range(0, 49) == 0) occupied = 9'($urandom);
            cycles(1);
        end
        btn = 3'b000;
        cycles(D + 10);

        chk("pending_strobes", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
